// File: rtl/spi_bus_arbiter.sv
// Purpose: grants the shared SPI pads (SCLK, MOSI, every chip select) to either
//          the memory controller or the peripheral engine, memory-first with a
//          bounded-starvation rule for the peripheral engine, and a guard gap between owners.
// Latency: a request sampled in IDLE is granted after the next edge. A release
//          sampled at edge N drops the grant after edge N. IDLE is reached after edge N+GUARD_CYCLES.
// Backpressure: req/gnt handshake with no preemption. The non-owner keeps waiting
//          with req held high, and its pins never reach the pads.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   mem_req / mem_gnt             memory engine request / ownership
//   mem_sclk, mem_mosi            memory engine SPI drive
//   mem_cs_ram_n, mem_cs_flash_n  memory engine chip selects
//   periph_req / periph_gnt       peripheral engine request / ownership
//   periph_sclk, periph_mosi      peripheral engine SPI drive
//   periph_cs_n[5:0]              [0]ADC [1]DAC [2]UART [3]ETH [4]GPIO [5]FLASH
//   spi_sclk, spi_mosi            pad drive
//   cs_ram_n, cs_flash_n          pad chip selects (flash is shared by both engines)
//   cs_periph_n[5:0]              pad chip selects, same index map as periph_cs_n
//   bus_busy                      high whenever the arbiter is not IDLE
//
// Parameters:
//   GUARD_CYCLES  idle cycles after every release, legal 1..15
//   STARVE_LIMIT  consecutive memory grants allowed while periph_req waits, legal 1..15

module spi_bus_arbiter #(
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_req,
  output logic       mem_gnt,
  input  logic       mem_sclk,
  input  logic       mem_mosi,
  input  logic       mem_cs_ram_n,
  input  logic       mem_cs_flash_n,
  input  logic       periph_req,
  output logic       periph_gnt,
  input  logic       periph_sclk,
  input  logic       periph_mosi,
  input  logic [5:0] periph_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       cs_ram_n,
  output logic       cs_flash_n,
  output logic [5:0] cs_periph_n,
  output logic       bus_busy
);

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [3:0] CNT_SAT    = 4'hF;
  localparam int         CS_FLASH   = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM    = 2'd1,
    ST_PERIPH = 2'd2,
    ST_GUARD  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] guard_cnt_q, guard_cnt_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       mem_gnt_q, mem_gnt_d;
  logic       periph_gnt_q, periph_gnt_d;
  logic       bus_busy_q, bus_busy_d;

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    guard_cnt_d  = guard_cnt_q;
    starve_cnt_d = starve_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // The peripheral engine wins a tie only once memory has taken
        // STARVE_LIMIT grants in a row while the peripheral engine was waiting.
        if (periph_req && (!mem_req || (starve_cnt_q == STARVE_MAX))) begin
          state_d      = ST_PERIPH;
          starve_cnt_d = '0;
        end else if (mem_req) begin
          state_d = ST_MEM;
          if (periph_req) begin
            starve_cnt_d = (starve_cnt_q == CNT_SAT) ? CNT_SAT : starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = '0;
          end
        end
      end

      ST_MEM: begin
        if (!mem_req) begin
          state_d     = ST_GUARD;
          guard_cnt_d = GUARD_LOAD;
        end
      end

      ST_PERIPH: begin
        if (!periph_req) begin
          state_d     = ST_GUARD;
          guard_cnt_d = GUARD_LOAD;
        end
      end

      ST_GUARD: begin
        // Requests are deliberately ignored here. A waiting engine is picked up
        // in IDLE, so there is always at least one extra all-CS-high cycle.
        guard_cnt_d = (guard_cnt_q == 4'd0) ? 4'd0 : guard_cnt_q - 4'd1;
        if (guard_cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Grants and busy are registered and decoded from the next state, so they
    // always match the state register exactly.
    mem_gnt_d    = (state_d == ST_MEM);
    periph_gnt_d = (state_d == ST_PERIPH);
    bus_busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      guard_cnt_q  <= '0;
      starve_cnt_q <= '0;
      mem_gnt_q    <= 1'b0;
      periph_gnt_q <= 1'b0;
      bus_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      guard_cnt_q  <= guard_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_gnt_q    <= mem_gnt_d;
      periph_gnt_q <= periph_gnt_d;
      bus_busy_q   <= bus_busy_d;
    end
  end

  assign mem_gnt    = mem_gnt_q;
  assign periph_gnt = periph_gnt_q;
  assign bus_busy   = bus_busy_q;

  // Pad mux. It decodes only the registered state, so an asynchronous reset
  // parks the pads immediately. In IDLE/GUARD every CS is high and SCLK/MOSI are low.
  always_comb begin
    spi_sclk    = 1'b0;
    spi_mosi    = 1'b0;
    cs_ram_n    = 1'b1;
    cs_flash_n  = 1'b1;
    cs_periph_n = 6'h3F;

    unique case (state_q)
      ST_MEM: begin
        spi_sclk   = mem_sclk;
        spi_mosi   = mem_mosi;
        cs_ram_n   = mem_cs_ram_n;
        cs_flash_n = mem_cs_flash_n;
      end
      ST_PERIPH: begin
        spi_sclk    = periph_sclk;
        spi_mosi    = periph_mosi;
        // The peripheral engine reaches the flash through the shared flash pad,
        // so its own FLASH slot on the peripheral pads is held high.
        cs_flash_n  = periph_cs_n[CS_FLASH];
        cs_periph_n = {1'b1, periph_cs_n[4:0]};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
module tb_spi_bus_arbiter;

  localparam int GUARD = 2;
  localparam int SLIM  = 2;
  localparam int OWN_NONE = 0;
  localparam int OWN_MEM  = 1;
  localparam int OWN_PER  = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_a  = 2'b00;    // [0]=mem  [1]=periph
  logic [1:0] sclk_a = 2'b00;
  logic [1:0] mosi_a = 2'b00;
  logic [1:0] mem_cs = 2'b11;    // [0]=ram  [1]=flash
  logic [5:0] per_cs = 6'h3F;

  logic       mem_gnt, periph_gnt, spi_sclk, spi_mosi, cs_ram_n, cs_flash_n, bus_busy;
  logic [5:0] cs_periph_n;
  logic [1:0] gnt_v;
  assign gnt_v = {periph_gnt, mem_gnt};

  spi_bus_arbiter #(.GUARD_CYCLES(GUARD), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(req_a[0]), .mem_gnt(mem_gnt),
    .mem_sclk(sclk_a[0]), .mem_mosi(mosi_a[0]),
    .mem_cs_ram_n(mem_cs[0]), .mem_cs_flash_n(mem_cs[1]),
    .periph_req(req_a[1]), .periph_gnt(periph_gnt),
    .periph_sclk(sclk_a[1]), .periph_mosi(mosi_a[1]),
    .periph_cs_n(per_cs),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .cs_ram_n(cs_ram_n), .cs_flash_n(cs_flash_n), .cs_periph_n(cs_periph_n),
    .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: the bus is free or owned. A release frees it for
  // arbitration GUARD+1 edges later. The tie rule counts memory wins in a row.
  int edge_n = 0;
  int own = OWN_NONE;
  int free_edge = 0;
  int streak = 0;
  logic [12:0] exp_q[$];

  function automatic logic [12:0] expect_vec(input int o, input logic busy_gap);
    case (o)
      OWN_MEM: return {1'b1, 1'b0, 1'b1, sclk_a[0], mosi_a[0], mem_cs[0], mem_cs[1], 6'h3F};
      OWN_PER: return {1'b0, 1'b1, 1'b1, sclk_a[1], mosi_a[1], 1'b1, per_cs[5], 1'b1, per_cs[4:0]};
      default: return {1'b0, 1'b0, busy_gap, 1'b0, 1'b0, 1'b1, 1'b1, 6'h3F};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own = OWN_NONE;
      free_edge = 0;
      streak = 0;
      exp_q.delete();
    end else begin
      edge_n++;
      if (own == OWN_NONE) begin
        if (edge_n >= free_edge && (req_a[0] || req_a[1])) begin
          if (req_a[1] && (!req_a[0] || streak == SLIM)) begin
            own = OWN_PER;
            streak = 0;
          end else begin
            own = OWN_MEM;
            streak = req_a[1] ? ((streak < 15) ? streak + 1 : 15) : 0;
          end
        end
      end else if ((own == OWN_MEM && !req_a[0]) || (own == OWN_PER && !req_a[1])) begin
        own = OWN_NONE;
        free_edge = edge_n + GUARD + 1;
      end
      exp_q.push_back(expect_vec(own, edge_n < free_edge - 1));
    end
  end

  // Monitor: each cycle the DUT presents a new output vector. The monitor pops
  // the expected vector and compares the two, and it logs the grant order.
  logic pm = 1'b0, pp = 1'b0;
  int gorder[$];
  logic [12:0] e_vec;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e_vec = exp_q.pop_front();
        chk($sformatf("cycle_outputs_edge%0d", edge_n),
            {mem_gnt, periph_gnt, bus_busy, spi_sclk, spi_mosi, cs_ram_n, cs_flash_n, cs_periph_n},
            e_vec);
      end
      if (mem_gnt && !pm) gorder.push_back(0);
      if (periph_gnt && !pp) gorder.push_back(1);
    end
    pm = mem_gnt;
    pp = periph_gnt;
  end

  // Engine behaviour and random pin activity.
  bit run = 1'b0;
  bit rand_data = 1'b0;
  int idle_lo = 0, idle_hi = 0, hold_lo = 0, hold_hi = 0, pulse_pct = 0;

  always @(negedge clk) begin
    if (rand_data) begin
      sclk_a = 2'($urandom);
      mosi_a = 2'($urandom);
      mem_cs = 2'($urandom);
      per_cs = 6'($urandom);
    end
  end

  task automatic engine(input int id);
    int n;
    int w;
    while (run) begin
      n = int'($urandom_range(idle_hi, idle_lo));
      repeat (n) @(negedge clk);
      if (!run) break;
      req_a[id] = 1'b1;
      @(negedge clk);
      if (int'($urandom_range(99)) >= pulse_pct) begin
        w = 0;
        while (!gnt_v[id] && w < 300) begin
          @(negedge clk);
          w++;
        end
        chk($sformatf("gnt_wait_eng%0d", id), 32'(gnt_v[id]), 32'd1);
        n = int'($urandom_range(hold_hi, hold_lo));
        repeat (n) @(negedge clk);
      end
      req_a[id] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic park_pins();
    sclk_a = 2'b00;
    mosi_a = 2'b00;
    mem_cs = 2'b11;
    per_cs = 6'h3F;
  endtask

  initial begin
    int w;
    int g;
    logic [5:0] ord;

    // Outputs must stay parked during reset, even while the engines drive requests and CS.
    req_a = 2'b11; mem_cs = 2'b00; per_cs = 6'h00; sclk_a = 2'b11; mosi_a = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_gnt_busy", {mem_gnt, periph_gnt, bus_busy}, 3'b000);
    chk("reset_pads", {spi_sclk, spi_mosi, cs_ram_n, cs_flash_n, cs_periph_n}, {2'b00, 2'b11, 6'h3F});
    @(negedge clk);
    req_a = 2'b00;
    park_pins();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single grant and release.
    req_a[0] = 1'b1;
    @(posedge clk); #1;
    chk("grant_latency", mem_gnt, 1);
    repeat (10) @(negedge clk);
    req_a[0] = 1'b0;
    @(posedge clk); #1;
    chk("release_gnt_low", {mem_gnt, bus_busy}, 2'b01);
    @(posedge clk); #1;
    chk("guard_busy", bus_busy, 1);
    @(posedge clk); #1;
    chk("guard_done_idle", bus_busy, 0);

    // Asynchronous reset in the middle of a memory transaction.
    @(negedge clk);
    req_a[0] = 1'b1; mem_cs = 2'b10; sclk_a = 2'b01;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_reset_own", {mem_gnt, cs_ram_n, spi_sclk}, 3'b101);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid", {mem_gnt, cs_ram_n, spi_sclk, bus_busy}, 4'b0100);
    @(negedge clk);
    req_a = 2'b00;
    park_pins();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Both engines request continuously. With STARVE_LIMIT=2 the grants go M M P M M P.
    idle_lo = 0; idle_hi = 0; hold_lo = 3; hold_hi = 3; pulse_pct = 0;
    gorder.delete();
    run = 1'b1;
    fork
      engine(0);
      engine(1);
      begin
        w = 0;
        while (gorder.size() < 6 && w < 400) begin
          @(negedge clk);
          w++;
        end
        run = 1'b0;
      end
    join
    for (int i = 0; i < 6; i++) ord[5-i] = (i < gorder.size()) ? gorder[i][0] : 1'bx;
    chk("starve_grant_order", ord, 6'b001001);
    repeat (GUARD + 3) @(negedge clk);

    // Random traffic: random idle gaps, hold times, one-cycle pulses and pin activity.
    idle_lo = 0; idle_hi = 4; hold_lo = 0; hold_hi = 6; pulse_pct = 20;
    rand_data = 1'b1;
    run = 1'b1;
    fork
      engine(0);
      engine(1);
      begin
        repeat (3000) @(negedge clk);
        run = 1'b0;
      end
    join
    rand_data = 1'b0;
    @(negedge clk);
    park_pins();
    repeat (GUARD + 3) @(negedge clk);

    // Flash routing from the peripheral engine, no preemption, then the release-to-grant gap.
    req_a[1] = 1'b1;
    w = 0;
    @(negedge clk);
    while (!periph_gnt && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("periph_grant", periph_gnt, 1);
    per_cs = 6'h15; mem_cs = 2'b00;
    #1;
    chk("flash_via_periph", {cs_flash_n, cs_ram_n, cs_periph_n}, {1'b0, 1'b1, 6'h35});
    @(negedge clk);
    req_a[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_preempt", {mem_gnt, periph_gnt}, 2'b01);
    end
    req_a[1] = 1'b0;
    per_cs = 6'h3F;
    g = 0;
    @(negedge clk);
    while (!mem_gnt && g < 20) begin
      g++;
      @(negedge clk);
    end
    chk("release_to_grant_gap", g, GUARD + 1);

    // In MEM the peripheral engine's pins must not reach the pads.
    mem_cs = 2'b01; per_cs = 6'h00; sclk_a = 2'b10; mosi_a = 2'b01;
    #1;
    chk("isolation_mem", {spi_sclk, spi_mosi, cs_ram_n, cs_flash_n, cs_periph_n},
        {1'b0, 1'b1, 1'b1, 1'b0, 6'h3F});
    @(negedge clk);
    sclk_a = 2'b01;
    #1;
    chk("sclk_follows_mem", spi_sclk, 1);
    @(negedge clk);
    req_a[0] = 1'b0;
    park_pins();
    repeat (GUARD + 4) @(negedge clk);
    chk("final_idle", {bus_busy, mem_gnt, periph_gnt}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors + 0);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
